// File: rtl/loader_pkg.sv
// Shared types and constants for the sample loader: FSM state encoding and
// the bit positions of the player's CSR word.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        FILL,
        ARM,
        POLL,
        CHECK,
        FINISH
    } state_t;

    // Player CSR bit positions.
    localparam int CSR_RESET_N = 0;
    localparam int CSR_DONE    = 1;
    localparam int CSR_IRQ     = 2;

    // CSR write word: only the reset_n bit is ever driven, all other bits stay 0.
    function automatic logic [31:0] csr_word(input logic reset_n);
        logic [31:0] w;
        w              = '0;
        w[CSR_RESET_N] = reset_n;
        return w;
    endfunction

endpackage

// File: rtl/sample_loader.sv
// Upstream feeder for the qsys sample player. Holds the player in reset,
// streams samples into its buffer at consecutive addresses, releases reset,
// then polls the CSR done bit and pulses done_pulse when playback ends.
//
// Handshake: a sample transfers on any rising clk edge where s_valid and
// s_ready are both high; s_data must be stable while s_valid is high. s_ready
// is a registered output and never depends combinationally on s_valid.
//
// Every output is registered: strobes are set on the edge that enters the
// state which "owns" them, so they are high for exactly that state's cycle.
module sample_loader
    import loader_pkg::*;
#(
    parameter int timeBits    = 10,
    parameter int words_log_2 = 0,
    localparam int ADDR_W     = timeBits + words_log_2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   length,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    output logic              buffer_write,
    output logic [ADDR_W-1:0] buffer_address,
    output logic [31:0]       buffer_writedata,
    output logic              csr_write,
    output logic [31:0]       csr_writedata,
    output logic              csr_read,
    input  logic [31:0]       csr_readdata,
    output logic              busy,
    output logic              done_pulse,
    output state_t            state_dbg
);

    // A run of length 0 means a full buffer: 2**ADDR_W samples.
    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_t          state;
    logic [ADDR_W:0] cnt;
    logic [ADDR_W:0] len_m1;
    logic            seen_low;

    // Only the done bit of the CSR read word matters here.
    logic unused_csr_bits;
    assign unused_csr_bits = ^{csr_readdata[31:CSR_DONE+1], csr_readdata[CSR_DONE-1:0]};

    assign state_dbg = state;

    // Load-and-play sequencer: state, sample counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= '0;
            len_m1           <= '0;
            seen_low         <= 1'b0;
            s_ready          <= 1'b0;
            buffer_write     <= 1'b0;
            buffer_address   <= '0;
            buffer_writedata <= '0;
            csr_write        <= 1'b0;
            csr_writedata    <= '0;
            csr_read         <= 1'b0;
            busy             <= 1'b0;
            done_pulse       <= 1'b0;
        end else begin
            // Strobes default low so each is a single-cycle pulse.
            buffer_write <= 1'b0;
            csr_write    <= 1'b0;
            csr_read     <= 1'b0;
            done_pulse   <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        len_m1        <= ((length == '0) ? FULL : length) - ONE;
                        cnt           <= '0;
                        // Hold the player in reset (also clears its irq).
                        csr_write     <= 1'b1;
                        csr_writedata <= csr_word(1'b0);
                        busy          <= 1'b1;
                        state         <= HALT;
                    end
                end

                HALT: begin
                    s_ready <= 1'b1;
                    state   <= FILL;
                end

                FILL: begin
                    if (s_valid && s_ready) begin
                        buffer_write     <= 1'b1;
                        buffer_address   <= cnt[ADDR_W-1:0];
                        buffer_writedata <= s_data;
                        cnt              <= cnt + ONE;
                        if (cnt == len_m1) begin
                            // Release the player in the same cycle as the last
                            // buffer write; the two buses are independent.
                            s_ready       <= 1'b0;
                            csr_write     <= 1'b1;
                            csr_writedata <= csr_word(1'b1);
                            seen_low      <= 1'b0;
                            state         <= ARM;
                        end
                    end
                end

                ARM: begin
                    csr_read <= 1'b1;
                    state    <= POLL;
                end

                POLL: begin
                    // Read data arrives during CHECK.
                    state <= CHECK;
                end

                CHECK: begin
                    if (!csr_readdata[CSR_DONE]) begin
                        seen_low <= 1'b1;
                        csr_read <= 1'b1;
                        state    <= POLL;
                    end else if (seen_low) begin
                        done_pulse <= 1'b1;
                        state      <= FINISH;
                    end else begin
                        // done=1 before any done=0 is stale from the previous run.
                        csr_read <= 1'b1;
                        state    <= POLL;
                    end
                end

                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    s_ready <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_loader.sv
// Directed/randomized bench for sample_loader with a behavioural player model
// for CSR reads and an event log checked against the expected run outline.
module tb_sample_loader;
    import loader_pkg::*;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   length;
    logic              s_valid;
    logic              s_ready;
    logic [31:0]       s_data;
    logic              buffer_write;
    logic [ADDR_W-1:0] buffer_address;
    logic [31:0]       buffer_writedata;
    logic              csr_write;
    logic [31:0]       csr_writedata;
    logic              csr_read;
    logic [31:0]       csr_readdata = '0;
    logic              busy;
    logic              done_pulse;
    state_t            state_dbg;

    sample_loader #(.timeBits(10), .words_log_2(0)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .length           (length),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .buffer_write     (buffer_write),
        .buffer_address   (buffer_address),
        .buffer_writedata (buffer_writedata),
        .csr_write        (csr_write),
        .csr_writedata    (csr_writedata),
        .csr_read         (csr_read),
        .csr_readdata     (csr_readdata),
        .busy             (busy),
        .done_pulse       (done_pulse),
        .state_dbg        (state_dbg)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;

    int   cyc = 0;
    logic hs_edge = 1'b0;
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        hs_edge <= s_valid && s_ready && !reset;
    end

    // Player CSR model: done bit from a script, then a default; other bits random.
    bit rd_script[$];
    bit rd_default = 1'b1;
    always @(posedge clk) begin
        if (csr_read) begin
            bit v;
            v = (rd_script.size() > 0) ? rd_script.pop_front() : rd_default;
            csr_readdata <= ($urandom() & 32'hFFFF_FFFD) | {30'b0, v, 1'b0};
        end
    end

    // Event log, sampled mid-cycle
    logic [ADDR_W-1:0] wa_q[$];
    logic [31:0]       wd_q[$];
    int                ws_q[$];
    logic [31:0]       cd_q[$];
    int                cs_q[$];
    int                rs_q[$];
    int                ds_q[$];
    int                lat_viol = 0;
    int                bus_viol = 0;
    int                wd_viol  = 0;

    always @(negedge clk) begin
        if (buffer_write) begin
            wa_q.push_back(buffer_address);
            wd_q.push_back(buffer_writedata);
            ws_q.push_back(cyc);
        end
        if (buffer_write !== hs_edge) lat_viol++;
        if (csr_write) begin
            cd_q.push_back(csr_writedata);
            cs_q.push_back(cyc);
        end
        if (csr_writedata[31:1] != '0) wd_viol++;
        if (csr_write && csr_read) bus_viol++;
        if (csr_read) rs_q.push_back(cyc);
        if (done_pulse) ds_q.push_back(cyc);
    end

    // Scoreboard
    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int start_cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wa_q.delete(); wd_q.delete(); ws_q.delete();
        cd_q.delete(); cs_q.delete(); rs_q.delete(); ds_q.delete();
        exp_q.delete();
        lat_viol = 0; bus_viol = 0; wd_viol = 0;
    endtask

    // Number of reads the loader needs: first done=1 after some done=0.
    function automatic int reads_needed(input bit s[$]);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < s.size(); i++) begin
            if (!s[i]) seen = 1'b1;
            else if (seen) return i + 1;
        end
        return -1;
    endfunction

    function automatic bit pick_valid(input int mode, input int it);
        case (mode)
            0:       return 1'b1;
            1:       return (it % 2) == 0;
            default: return $urandom_range(0, 3) != 0;
        endcase
    endfunction

    // Driver tasks
    task automatic do_start(input int len_field, input bit record);
        start  = 1'b1;
        length = len_field[ADDR_W:0];
        if (record) start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int n, input int mode, input bit seq);
        int got, guard, it;
        got = 0; guard = 0; it = 0;
        while (!s_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("feed_ready_timeout", guard >= 50, 0);
        guard   = 0;
        s_valid = pick_valid(mode, it);
        s_data  = seq ? got + 1 : $urandom();
        while (got < n && guard < 6000) begin
            if (s_valid && s_ready) begin
                exp_q.push_back(s_data);
                got++;
            end
            tick();
            guard++;
            it++;
            if (got < n) begin
                s_valid = pick_valid(mode, it);
                s_data  = seq ? got + 1 : $urandom();
            end else begin
                s_valid = 1'b0;
            end
        end
        s_valid = 1'b0;
        check("feed_count", got, n);
    endtask

    task automatic wait_finish();
        int guard;
        guard = 0;
        while (!done_pulse && guard < 300) begin
            tick();
            guard++;
        end
        check("done_timeout", guard >= 300, 0);
        tick();
        check("busy_after_done", busy, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_strobes"}, {busy, s_ready, buffer_write, csr_write, csr_read, done_pulse}, 0);
        check({tag, "_addr"}, buffer_address, 0);
        check({tag, "_wdata"}, buffer_writedata, 0);
        check({tag, "_csr_wdata"}, csr_writedata, 0);
        check({tag, "_state"}, state_dbg, IDLE);
    endtask

    task automatic check_run(input int n, input int exp_r, input bit consecutive);
        int bad;
        check("wr_count", wa_q.size(), n);
        bad = 0;
        for (int i = 0; i < wa_q.size(); i++)
            if (i >= exp_q.size() || wa_q[i] !== i[ADDR_W-1:0] || wd_q[i] !== exp_q[i]) bad++;
        check("wr_content", bad, 0);
        if (consecutive) begin
            bad = 0;
            for (int i = 1; i < ws_q.size(); i++)
                if (ws_q[i] != ws_q[0] + i) bad++;
            check("wr_back_to_back", bad, 0);
        end
        check("csr_wr_count", cd_q.size(), 2);
        if (cd_q.size() >= 2 && ws_q.size() > 0) begin
            check("csr_halt_data", cd_q[0], 0);
            check("csr_arm_data", cd_q[1], 1);
            check("halt_latency", cs_q[0], start_cyc + 1);
            check("halt_before_fill", cs_q[0] < ws_q[0], 1);
            check("arm_overlap", cs_q[1], ws_q[ws_q.size()-1]);
        end
        check("poll_reads", rs_q.size(), exp_r);
        bad = 0;
        for (int i = 1; i < rs_q.size(); i++)
            if (rs_q[i] - rs_q[i-1] != 2) bad++;
        check("poll_period", bad, 0);
        check("done_count", ds_q.size(), 1);
        if (rs_q.size() > 0 && ds_q.size() > 0)
            check("done_after_read", ds_q[0], rs_q[rs_q.size()-1] + 2);
        check("handshake_latency", lat_viol, 0);
        check("bus_conflict", bus_viol, 0);
        check("csr_high_bits", wd_viol, 0);
    endtask

    // Directed sequence
    initial begin
        bit sc[$];
        int er, nb;

        reset = 1'b1; start = 1'b0; length = '0; s_valid = 1'b0; s_data = '0;
        repeat (3) tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();

        // Basic run: 4 sequential samples, done script 1,0,0,1
        clear_logs();
        sc = '{1'b1, 1'b0, 1'b0, 1'b1};
        er = reads_needed(sc);
        rd_script = sc;
        do_start(4, 1'b1);
        feed(4, 0, 1'b1);
        wait_finish();
        check_run(4, er, 1'b1);
        check("basic_reads_model", er, 4);

        // Backpressure: valid toggles over 3 samples
        clear_logs();
        sc = '{1'b0, 1'b1};
        er = reads_needed(sc);
        rd_script = sc;
        do_start(3, 1'b1);
        feed(3, 1, 1'b0);
        wait_finish();
        check_run(3, er, 1'b0);

        // Full buffer: length 0 means 1024 samples, random valid
        clear_logs();
        sc.delete();
        nb = $urandom_range(0, 3);
        for (int i = 0; i < nb; i++) sc.push_back(1'b1);
        sc.push_back(1'b0);
        sc.push_back(1'b1);
        er = reads_needed(sc);
        rd_script = sc;
        do_start(0, 1'b1);
        feed(1024, 2, 1'b0);
        wait_finish();
        check_run(1024, er, 1'b0);
        if (wa_q.size() > 0) check("full_last_addr", wa_q[wa_q.size()-1], 1023);

        // Stale done: done stays 1, never completes
        clear_logs();
        rd_script.delete();
        rd_default = 1'b1;
        do_start(2, 1'b1);
        feed(2, 0, 1'b0);
        repeat (40) tick();
        check("stale_no_done", ds_q.size(), 0);
        check("stale_busy", busy, 1);
        check("stale_read_count", rs_q.size() >= 15, 1);
        nb = 0;
        for (int i = 1; i < rs_q.size(); i++)
            if (rs_q[i] - rs_q[i-1] != 2) nb++;
        check("stale_poll_period", nb, 0);
        if (rs_q.size() > 0 && ws_q.size() > 0)
            check("stale_first_read", rs_q[0], ws_q[ws_q.size()-1] + 1);
        reset = 1'b1;
        tick();
        check_idle_outputs("stale_reset");
        reset = 1'b0;

        // Reset mid-fill after 2 of 8 writes
        clear_logs();
        do_start(8, 1'b1);
        feed(2, 0, 1'b0);
        reset = 1'b1;
        tick();
        check_idle_outputs("midrun_reset");
        reset = 1'b0;
        clear_logs();
        repeat (10) tick();
        check("midrun_no_csr", cd_q.size(), 0);
        check("midrun_no_wr", wa_q.size(), 0);

        // Clean run after the abandoned one
        clear_logs();
        sc = '{1'b0, 1'b1};
        er = reads_needed(sc);
        rd_script = sc;
        do_start(3, 1'b1);
        feed(3, 2, 1'b0);
        wait_finish();
        check_run(3, er, 1'b0);

        // start pulsed during FILL must be ignored
        clear_logs();
        sc = '{1'b0, 1'b0, 1'b1};
        er = reads_needed(sc);
        rd_script = sc;
        do_start(5, 1'b1);
        feed(2, 0, 1'b0);
        do_start(2, 1'b0);
        feed(3, 0, 1'b0);
        wait_finish();
        check_run(5, er, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
